// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and sequencer state encoding for the LCD frame refresher
package lcd_pkg;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int CHARS_PER_LINE = 16;
  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    SET_ADDR,
    WAIT_ADDR,
    WRITE_CHAR,
    WAIT_CHAR
  } state_t;
endpackage

// File: rtl/lcd_char_buffer.sv
// lcd_char_buffer: 32x8 character store, space-filled on reset, one write port and one async read port
module lcd_char_buffer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [32];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 32; i++) mem[i] <= CHAR_SPACE;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: refreshes a 2x16 LCD from a character buffer via set-address/write-data transactions
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter bit AUTO_REFRESH   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       refresh_req,
  output logic       do_set_dd_ram_addr,
  output logic [6:0] dd_ram_addr,
  input  logic       set_dd_ram_addr_done,
  output logic       do_write_data,
  output logic [7:0] data_to_write,
  input  logic       send_data_done,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] LAST0 = 5'(CHARS_PER_LINE - 1);
  localparam logic [4:0] LAST1 = 5'(2 * CHARS_PER_LINE - 1);
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pending, pend_n, terr_n, fdone_n, timed_out;
  logic [7:0] rdata, char_n;
  lcd_char_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (buf_data),
    .raddr (idx_n),
    .rdata (rdata)
  );
  assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign char_n = (buf_we && buf_addr == idx_n) ? buf_data : rdata;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    pend_n  = pending | (busy & refresh_req);
    cnt_n   = cnt + 1'b1;
    terr_n  = timeout_err;
    fdone_n = 1'b0;
    case (state)
      WAIT_INIT:
        if (init_done) begin
          state_n = AUTO_REFRESH ? SET_ADDR : IDLE;
          if (AUTO_REFRESH) begin
            idx_n  = '0;
            pend_n = 1'b0;
            terr_n = 1'b0;
          end
        end
      IDLE:
        if (refresh_req || pending) begin
          state_n = SET_ADDR;
          idx_n   = '0;
          pend_n  = 1'b0;
          terr_n  = 1'b0;
        end
      SET_ADDR: begin
        state_n = WAIT_ADDR;
        cnt_n   = '0;
      end
      WAIT_ADDR:
        if (set_dd_ram_addr_done) state_n = WRITE_CHAR;
        else if (timed_out) begin
          state_n = IDLE;
          terr_n  = 1'b1;
          pend_n  = 1'b0;
        end
      WRITE_CHAR: begin
        state_n = WAIT_CHAR;
        cnt_n   = '0;
      end
      WAIT_CHAR:
        if (send_data_done) begin
          idx_n   = idx == LAST1 ? '0 : idx + 1'b1;
          state_n = idx == LAST0 ? SET_ADDR : idx == LAST1 ? IDLE : WRITE_CHAR;
          fdone_n = idx == LAST1;
        end else if (timed_out) begin
          state_n = IDLE;
          terr_n  = 1'b1;
          pend_n  = 1'b0;
        end
      default: state_n = WAIT_INIT;
    endcase
    if (!init_done && state != WAIT_INIT) begin
      state_n = WAIT_INIT;
      fdone_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state              <= WAIT_INIT;
      idx                <= '0;
      pending            <= 1'b0;
      cnt                <= '0;
      do_set_dd_ram_addr <= 1'b0;
      do_write_data      <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      timeout_err        <= 1'b0;
      dd_ram_addr        <= LINE0_BASE;
      data_to_write      <= CHAR_SPACE;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      pending            <= pend_n;
      cnt                <= cnt_n;
      do_set_dd_ram_addr <= state_n == SET_ADDR;
      do_write_data      <= state_n == WRITE_CHAR;
      busy               <= state_n inside {SET_ADDR, WAIT_ADDR, WRITE_CHAR, WAIT_CHAR};
      frame_done         <= fdone_n;
      timeout_err        <= terr_n;
      dd_ram_addr        <= state_n == SET_ADDR ? (idx_n[4] ? LINE1_BASE : LINE0_BASE) : dd_ram_addr;
      data_to_write      <= state_n == WRITE_CHAR ? char_n : data_to_write;
    end
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: scoreboard plus table-driven checks of the LCD frame sequencer
module tb_lcd_frame_sequencer;
  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;
  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         slot;
  } vec_t;
  logic clk = 1'b0, reset, init_done, buf_we, refresh_req, set_done, send_done;
  logic [4:0] buf_addr;
  logic [7:0] buf_data, data_to_write;
  logic [6:0] dd_ram_addr;
  logic do_set_dd_ram_addr, do_write_data, busy, frame_done, timeout_err;
  int tests = 0, fails = 0, cyc = 0, last_done_cyc = 0, wcap = 0, ncmd = 0, rcount = 0;
  bit withhold = 0;
  ev_t q[$];
  logic [7:0] mbuf[32];
  logic [7:0] cap[32];
  vec_t tbl[6];
  lcd_frame_sequencer #(.TIMEOUT_CYCLES(100), .AUTO_REFRESH(1'b1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .init_done            (init_done),
    .buf_we               (buf_we),
    .buf_addr             (buf_addr),
    .buf_data             (buf_data),
    .refresh_req          (refresh_req),
    .do_set_dd_ram_addr   (do_set_dd_ram_addr),
    .dd_ram_addr          (dd_ram_addr),
    .set_dd_ram_addr_done (set_done),
    .do_write_data        (do_write_data),
    .data_to_write        (data_to_write),
    .send_data_done       (send_done),
    .busy                 (busy),
    .frame_done           (frame_done),
    .timeout_err          (timeout_err)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push_frame();
    q.push_back('{2'd1, 8'h00});
    for (int i = 0; i < 16; i++) q.push_back('{2'd2, mbuf[i]});
    q.push_back('{2'd1, 8'h40});
    for (int i = 16; i < 32; i++) q.push_back('{2'd2, mbuf[i]});
    q.push_back('{2'd3, 8'h00});
  endtask
  task automatic buf_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    buf_we = 1'b1;
    buf_addr = a;
    buf_data = d;
    mbuf[a] = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask
  task automatic refresh(input bit push);
    @(negedge clk);
    refresh_req = 1'b1;
    if (push) push_frame();
    @(negedge clk);
    refresh_req = 1'b0;
  endtask
  task automatic wait_frame_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2000);
    check("frame_done_wait", frame_done, 1);
  endtask
  task automatic wait_writes(input int k);
    int n = 0, w = 0;
    while (w < k && n < 1000) begin
      @(negedge clk);
      n++;
      if (do_write_data) w++;
    end
    check("writes_reached", w, k);
  endtask
  task automatic check_reset_outputs();
    check("rst_do_set", do_set_dd_ram_addr, 0);
    check("rst_do_write", do_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_dd_ram_addr", dd_ram_addr, 7'h00);
    check("rst_data_to_write", data_to_write, 8'h20);
  endtask
  initial begin
    set_done = 1'b0;
    send_done = 1'b0;
    forever begin
      logic go, is_set, abort;
      @(negedge clk);
      set_done = 1'b0;
      send_done = 1'b0;
      if (do_set_dd_ram_addr && dd_ram_addr == 7'h00) rcount = 0;
      go = do_set_dd_ram_addr || (do_write_data && !(withhold && rcount == 7));
      is_set = do_set_dd_ram_addr;
      if (do_write_data) rcount++;
      if (go && !reset && init_done) begin
        abort = 1'b0;
        repeat (2) begin
          @(negedge clk);
          if (reset || !init_done) abort = 1'b1;
        end
        if (!abort) begin
          if (is_set) set_done = 1'b1;
          else send_done = 1'b1;
          last_done_cyc = cyc;
        end
      end
    end
  end
  initial forever begin
    logic [1:0] k;
    logic [7:0] v;
    ev_t e;
    @(negedge clk);
    if (do_set_dd_ram_addr || do_write_data || frame_done) begin
      k = do_set_dd_ram_addr ? 2'd1 : do_write_data ? 2'd2 : 2'd3;
      v = do_set_dd_ram_addr ? {1'b0, dd_ram_addr} : do_write_data ? data_to_write : 8'h00;
      if (k != 2'd3) ncmd++;
      if (q.size() == 0) check("unexpected_event", {22'd0, k, v}, 0);
      else begin
        e = q.pop_front();
        check("event_kind", k, e.kind);
        check("event_value", v, e.val);
        if (k != 2'd3 && !(k == 2'd1 && v == 8'h00)) check("done_to_cmd_latency", cyc - last_done_cyc, 1);
      end
      if (frame_done) check("busy_low_at_frame_done", busy, 0);
      if (do_set_dd_ram_addr && dd_ram_addr == 7'h00) wcap = 0;
      if (do_write_data) begin
        if (wcap < 32) cap[wcap] = data_to_write;
        wcap++;
      end
    end
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0;
    int n;
    tbl[0] = '{5'd0, 8'h48, 0};
    tbl[1] = '{5'd1, 8'h45, 1};
    tbl[2] = '{5'd2, 8'h4C, 2};
    tbl[3] = '{5'd3, 8'h4C, 3};
    tbl[4] = '{5'd4, 8'h4F, 4};
    tbl[5] = '{5'd16, 8'h58, 16};
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    reset = 1'b1;
    init_done = 1'b1;
    buf_we = 1'b0;
    buf_addr = '0;
    buf_data = '0;
    refresh_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    push_frame();
    reset = 1'b0;
    wait_frame_done();
    repeat (2) @(negedge clk);
    check("auto_frame_drained", q.size(), 0);
    for (int i = 0; i < 6; i++) buf_write(tbl[i].addr, tbl[i].data);
    refresh(1);
    check("refresh_busy_k1", busy, 1);
    check("refresh_set_k1", do_set_dd_ram_addr, 1);
    wait_frame_done();
    for (int i = 0; i < 6; i++) check("table_char", cap[tbl[i].slot], tbl[i].data);
    refresh(1);
    repeat (10) @(negedge clk);
    refresh(1);
    repeat (3) @(negedge clk);
    refresh(0);
    repeat (3) @(negedge clk);
    refresh(0);
    wait_frame_done();
    check("gap_idle_busy", busy, 0);
    @(negedge clk);
    check("pending_busy", busy, 1);
    check("pending_set", do_set_dd_ram_addr, 1);
    wait_frame_done();
    repeat (20) @(negedge clk);
    check("collapsed_busy", busy, 0);
    check("collapsed_drained", q.size(), 0);
    withhold = 1;
    refresh(1);
    wait_writes(8);
    repeat (100) @(negedge clk);
    check("pre_timeout_err", timeout_err, 0);
    check("pre_timeout_busy", busy, 1);
    @(negedge clk);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_busy", busy, 0);
    q.delete();
    withhold = 0;
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", timeout_err, 1);
    refresh(1);
    check("timeout_err_cleared", timeout_err, 0);
    check("restart_busy", busy, 1);
    wait_frame_done();
    refresh(1);
    wait_writes(20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q.delete();
    check_reset_outputs();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    reset = 1'b0;
    push_frame();
    wait_frame_done();
    check("post_reset_char0", cap[0], 8'h20);
    refresh(1);
    repeat (10) @(negedge clk);
    n = 0;
    while ((do_set_dd_ram_addr || do_write_data || frame_done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    init_done = 1'b0;
    q.delete();
    n0 = ncmd;
    repeat (30) @(negedge clk);
    check("init_drop_busy", busy, 0);
    check("init_drop_no_cmds", ncmd - n0, 0);
    push_frame();
    init_done = 1'b1;
    wait_frame_done();
    repeat (5) @(negedge clk);
    check("final_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
